// File: rtl/sd_cic_pkg.sv
// ---------------------------------------------------------------------------
// sd_cic_pkg
// Shared helpers for the delta-sigma CIC decimator.
//   cic_width(n, r)  : internal/output width that holds the exact comb result
//                      for n stages at decimation ratio r (gain r**n, signed).
//   bit_to_signed(b) : maps a bitstream bit to a 2-bit signed symbol,
//                      1 -> +1, 0 -> -1.
// ---------------------------------------------------------------------------
package sd_cic_pkg;

   function automatic int cic_width(input int n, input int r);
      return n * $clog2(r) + 2;
   endfunction

   function automatic logic signed [1:0] bit_to_signed(input logic b);
      return b ? 2'sb01 : 2'sb11;
   endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// ---------------------------------------------------------------------------
// sd_cic_integrator
// One enabled modulo-2^W accumulator of the CIC integrator cascade.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset, clears the accumulator
//   en     : accumulate enable (an accepted input bit)
//   din    : value added this cycle (previous stage's updated value)
//   sum    : accumulator value after this cycle's update (combinational),
//            which feeds the next stage so the whole cascade updates together
// ---------------------------------------------------------------------------
module sd_cic_integrator #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sum
);

   logic [W-1:0] acc;

   // The updated value is exposed combinationally so that a cascade of these
   // behaves as pure integrators (no extra delay per stage); wrap-around is
   // intentional because the comb differences recover the exact result.
   assign sum = acc + din;

   // Hold the accumulator unless a bit is accepted this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/sd_cic_decimator.sv
// ---------------------------------------------------------------------------
// sd_cic_decimator
// N-stage CIC (Hogenauer) decimator turning a 1-bit delta-sigma stream into
// signed B-bit PCM samples, one per R accepted bits, with a one-entry
// valid/ready output buffer.
// Ports:
//   clk       : clock
//   reset     : asynchronous active-high reset, clears all state
//   in_bit    : bitstream bit (1 -> +1, 0 -> -1)
//   in_valid  : qualifies in_bit; input is never back-pressured
//   out_data  : signed two's-complement sample (B bits)
//   out_valid : a sample is held in the output buffer
//   out_ready : consumer accepts the held sample when high with out_valid
//   overrun   : sticky, a sample was overwritten before being accepted
// ---------------------------------------------------------------------------
module sd_cic_decimator
   import sd_cic_pkg::*;
#(
   parameter  int N = 3,
   parameter  int R = 64,
   localparam int B = cic_width(N, R)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_bit,
   input  logic         in_valid,
   output logic [B-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         overrun
);

   localparam int CW = $clog2(R);

   logic signed [1:0] in_sym;
   logic [B-1:0]      stage [N+1];
   logic [B-1:0]      comb_val [N+1];
   logic [B-1:0]      comb_prev [N];
   logic [CW-1:0]     dec_count;
   logic              strobe;

   // Sign-extend the +1/-1 symbol to the full internal width.
   assign in_sym   = bit_to_signed(in_bit);
   assign stage[0] = {{(B-2){in_sym[1]}}, in_sym};

   // Integrator cascade: each stage adds the previous stage's updated value,
   // so stage[N] is the final integrator value after this cycle's update.
   for (genvar i = 0; i < N; i++) begin : g_int
      sd_cic_integrator #(
         .W (B)
      ) u_int (
         .clk   (clk),
         .reset (reset),
         .en    (in_valid),
         .din   (stage[i]),
         .sum   (stage[i+1])
      );
   end

   // R is a power of two, so the counter wraps from R-1 to 0 on its own.
   assign strobe = in_valid && (dec_count == CW'(R - 1));

   // Count accepted bits; the R-th accepted bit produces the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_count <= '0;
      end else if (in_valid) begin
         dec_count <= dec_count + 1'b1;
      end
   end

   // Comb chain is purely combinational from the updated integrator value to
   // the output register, which keeps the latency at exactly one cycle.
   always_comb begin
      comb_val[0] = stage[N];
      for (int i = 0; i < N; i++) begin
         comb_val[i+1] = comb_val[i] - comb_prev[i];
      end
   end

   // Comb delay elements only advance at the decimated rate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            comb_prev[i] <= '0;
         end
      end else if (strobe) begin
         for (int i = 0; i < N; i++) begin
            comb_prev[i] <= comb_val[i];
         end
      end
   end

   // One-entry output buffer. A new sample always wins: it loads even when
   // the old one is unaccepted (flagging overrun), and an acceptance in the
   // same cycle as a new sample simply leaves out_valid high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (strobe) begin
         out_data  <= comb_val[N];
         out_valid <= 1'b1;
         if (out_valid && !out_ready) begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_sd_cic_decimator
// Self-checking bench for sd_cic_decimator. Instance A (N=3, R=8) is checked
// every cycle against a reference that treats the CIC as its equivalent FIR
// (boxcar of length R convolved N times) evaluated on the history of accepted
// bits every R-th bit, plus a rule-level model of the output buffer.
// Instance B (N=4, R=64) is run long enough for its integrators to wrap.
// ---------------------------------------------------------------------------
module tb_sd_cic_decimator;

   localparam int NA = 3;
   localparam int RA = 8;
   localparam int BA = NA * $clog2(RA) + 2;
   localparam int LA = NA * (RA - 1) + 1;
   localparam int NB = 4;
   localparam int RB = 64;
   localparam int BB = NB * $clog2(RB) + 2;

   logic clk = 1'b0;

   logic                 reset_a;
   logic                 in_bit_a;
   logic                 in_valid_a;
   logic                 out_ready_a;
   logic                 out_valid_a;
   logic                 overrun_a;
   logic signed [BA-1:0] out_data_a;

   logic                 reset_b;
   logic                 in_bit_b;
   logic                 in_valid_b;
   logic                 out_ready_b;
   logic                 out_valid_b;
   logic                 overrun_b;
   logic signed [BB-1:0] out_data_b;

   int tests_run    = 0;
   int tests_failed = 0;

   longint h [LA];
   int     hist [$];
   logic   m_valid;
   logic   m_overrun;
   longint m_data;

   sd_cic_decimator #(.N(NA), .R(RA)) dut_a (
      .clk       (clk),
      .reset     (reset_a),
      .in_bit    (in_bit_a),
      .in_valid  (in_valid_a),
      .out_data  (out_data_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .overrun   (overrun_a)
   );

   sd_cic_decimator #(.N(NB), .R(RB)) dut_b (
      .clk       (clk),
      .reset     (reset_b),
      .in_bit    (in_bit_b),
      .in_valid  (in_valid_b),
      .out_data  (out_data_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .overrun   (overrun_b)
   );

   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reduce to B bits modulo 2^B and reinterpret as signed.
   function automatic longint wrapA(input longint v);
      longint t;
      t = v <<< (64 - BA);
      return t >>> (64 - BA);
   endfunction

   // Equivalent FIR output for the newest accepted bit; bits before reset
   // count as zero.
   function automatic longint cicRef();
      longint y;
      int     idx;
      y = 0;
      for (int j = 0; j < LA; j++) begin
         idx = hist.size() - 1 - j;
         if (idx >= 0) y += h[j] * longint'(hist[idx]);
      end
      return wrapA(y);
   endfunction

   task automatic modelClear();
      hist.delete();
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_data    = 0;
   endtask

   // Reference model of instance A, advanced on each active edge.
   always @(posedge clk) begin
      logic   new_s;
      longint new_val;
      if (reset_a) begin
         modelClear();
      end else begin
         new_s   = 1'b0;
         new_val = 0;
         if (in_valid_a) begin
            hist.push_back(in_bit_a ? 1 : -1);
            if (hist.size() % RA == 0) begin
               new_s   = 1'b1;
               new_val = cicRef();
            end
         end
         if (new_s) begin
            if (m_valid && !out_ready_a) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_data  = new_val;
         end else if (m_valid && out_ready_a) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic compareA();
      checkOutput("a_valid", out_valid_a, m_valid);
      checkOutput("a_overrun", overrun_a, m_overrun);
      checkOutput("a_data", out_data_a, m_data);
   endtask

   // bit_mode: 0 ones, 1 zeros, 2 alternating 1,0, 3 pattern 1,1,1,0, 4 random
   // valid_mode: 0 always, 1 every other cycle, 2 random
   // ready_mode: 0 always, 1 never, 2 random 75%, 3 only on strobe cycles
   task automatic applyStimulus(input int cycles, input int bit_mode,
                                input int valid_mode, input int ready_mode);
      int   pos;
      logic v;
      logic b;
      logic r;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         compareA();
         pos = hist.size();
         case (valid_mode)
            0:       v = 1'b1;
            1:       v = (c % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         case (bit_mode)
            0:       b = 1'b1;
            1:       b = 1'b0;
            2:       b = (pos % 2 == 0);
            3:       b = (pos % 4 != 3);
            default: b = 1'($urandom_range(0, 1));
         endcase
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = 1'b0;
            2:       r = ($urandom_range(0, 3) != 0);
            default: r = v && ((pos + 1) % RA == 0);
         endcase
         in_valid_a  = v;
         in_bit_a    = b;
         out_ready_a = r;
      end
   endtask

   task automatic applyReset(input int cycles);
      @(negedge clk);
      compareA();
      reset_a    = 1'b1;
      in_valid_a = 1'b0;
      modelClear();
      repeat (cycles) begin
         @(negedge clk);
         compareA();
      end
      reset_a = 1'b0;
   endtask

   initial begin
      longint cur [$];
      longint nxt [$];

      // Impulse response of N cascaded length-R boxcars.
      cur = {64'sd1};
      for (int s = 0; s < NA; s++) begin
         nxt.delete();
         for (int i = 0; i < cur.size() + RA - 1; i++) nxt.push_back(0);
         for (int i = 0; i < cur.size(); i++) begin
            for (int j = 0; j < RA; j++) nxt[i+j] += cur[i];
         end
         cur = nxt;
      end
      for (int j = 0; j < LA; j++) h[j] = cur[j];

      reset_a = 1'b1; in_bit_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
      reset_b = 1'b1; in_bit_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      modelClear();
      repeat (2) @(negedge clk);
      compareA();
      checkOutput("reset_b_data", out_data_b, 0);
      checkOutput("reset_b_valid", out_valid_b, 0);
      reset_a = 1'b0;

      $display("[TB] constant ones");
      applyStimulus(60, 0, 0, 0);
      checkOutput("const1_settled", out_data_a, 512);
      checkOutput("const1_no_overrun", overrun_a, 0);

      $display("[TB] constant zeros");
      applyReset(1);
      applyStimulus(60, 1, 0, 0);
      checkOutput("const0_settled", out_data_a, -512);

      $display("[TB] alternating 1,0");
      applyReset(1);
      applyStimulus(60, 2, 0, 0);
      checkOutput("alt_settled", out_data_a, 0);

      $display("[TB] pattern 1,1,1,0");
      applyReset(1);
      applyStimulus(60, 3, 0, 0);
      checkOutput("p1110_settled", out_data_a, 256);

      $display("[TB] in_valid 50 percent");
      applyReset(1);
      applyStimulus(120, 0, 1, 0);
      checkOutput("half_rate_settled", out_data_a, 512);

      $display("[TB] consumer stalled across two strobes");
      applyReset(1);
      applyStimulus(20, 0, 0, 1);
      checkOutput("overrun_set", overrun_a, 1);
      applyStimulus(20, 0, 0, 0);
      checkOutput("overrun_sticky", overrun_a, 1);

      $display("[TB] acceptance on the strobe cycle");
      applyReset(1);
      applyStimulus(80, 0, 0, 3);
      checkOutput("same_cycle_no_overrun", overrun_a, 0);
      checkOutput("same_cycle_valid_high", out_valid_a, 1);

      $display("[TB] reset mid-frame");
      applyReset(1);
      applyStimulus(5, 0, 0, 0);
      applyReset(1);
      applyStimulus(60, 0, 0, 0);
      checkOutput("post_reset_settled", out_data_a, 512);

      $display("[TB] random traffic");
      applyReset(1);
      applyStimulus(3000, 4, 2, 2);
      applyReset(1);

      $display("[TB] long run N=4 R=64");
      @(negedge clk);
      in_bit_b    = 1'b1;
      in_valid_b  = 1'b1;
      out_ready_b = 1'b1;
      reset_b     = 1'b0;
      for (int c = 1; c <= 20000; c++) begin
         @(negedge clk);
         checkOutput("b_valid", out_valid_b, (c % RB == 0) ? 1 : 0);
         if (c % RB == 0) begin
            if (c / RB == 1) begin
               checkOutput("b_first_partial", out_data_b, 766480);
            end else if (c / RB - 1 >= NB) begin
               checkOutput("b_settled", out_data_b, 16777216);
            end
         end
      end
      checkOutput("b_no_overrun", overrun_b, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sd_cic_decimator.md
# sd_cic_decimator

Reconstructs multi-bit PCM samples from a 1-bit delta-sigma bitstream with an N-stage CIC (Hogenauer) decimation filter. It is the receiving end of the modulator chain: it sits between the modulator output (or loop bitstream tap) and the PSD/measurement path. It delivers one signed sample per R accepted input bits on a valid/ready output port.

## Interface
- `N`, 3: number of integrator and comb stages (1..6).
- `R`, 64: decimation ratio; power of two, 2..1024; differential delay fixed at 1.
- `B`, `N*$clog2(R)+2`: internal and output width; derived, never overridden.
- `clk`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high.
- `in_bit`  in  1  bitstream; 1 maps to +1, 0 maps to -1.
- `in_valid`  in  1  qualifies `in_bit`; the block never back-pressures its input.
- `out_data`  out  B  signed two's-complement sample.
- `out_valid`  out  1  sample available.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `overrun`  out  1  sticky; a sample was overwritten before it was accepted.

## Operation
- Reset values: integrators 0, comb delays 0, decimation counter 0, `out_data` 0, `out_valid` 0, `overrun` 0.
- Integrator stage i adds stage i-1 (stage 0 input: +1/-1 sign-extended to B bits) on every cycle with `in_valid`=1. All stages hold otherwise.
- All arithmetic is B-bit modulo 2^B. Wrap-around in the integrators is intended and must not be saturated. B is sufficient for exact comb output.
- Decimation counter counts accepted bits 0..R-1 and wraps. A decimation strobe occurs on the cycle `in_valid`=1 with counter = R-1.
- On a strobe, the comb chain consumes the final integrator value after that cycle's update. Each comb stage computes y = x - x_prev and updates x_prev. The comb result is registered into `out_data`.
- Output port: one-entry buffer.
  - `out_valid` is set by a new sample.
  - `out_valid` is cleared by `out_valid & out_ready` when no new sample arrives that cycle.
  - New sample while `out_valid`=1 and `out_ready`=0: overwrite `out_data`, keep `out_valid`=1, set `overrun`.
  - New sample in the same cycle as acceptance: the new sample loads, `out_valid` stays 1, no overrun.
- `overrun` clears only on `reset`.
- Startup transient: the first N outputs are partial-response values. Outputs from index N (0-based) onward are settled. The block does not flag the transient.
- Reset mid-operation clears all state immediately. The next decimation strobe is the R-th bit accepted after reset deassertion.

## Timing
- Strobe on cycle k gives `out_valid`=1 and new `out_data` at cycle k+1. Total latency is 1 cycle after the R-th bit.
- The comb chain is combinational between the strobe register inputs and `out_data`. Registering per stage is not permitted, so latency stays fixed at 1.
- Maximum sustained rate: `in_valid` every cycle yields one sample every R cycles. The consumer must accept within R cycles to avoid overrun.
- Gain is R^N. Full-scale constant input gives ±R^N settled output.

## Structure
- Package `sd_cic_pkg`: function `cic_width(N,R)` returning `N*$clog2(R)+2`, and a bit-to-signed mapping function. The top module uses this package; no testbench content goes in it.
- Sub-module `sd_cic_integrator`: one B-bit enabled accumulator. It is instantiated N times in a generate loop.
- Combs, decimation counter and output buffer live in the top module.
- Expected size: ~150-250 lines of RTL.

## Test plan
- N=3, R=8, `in_bit`=1 and `in_valid`=1 continuously, `out_ready`=1. Outputs arrive every 8 cycles, first at cycle 9 after reset release. Output index ≥2 equals +512. `overrun` stays 0.
- Same configuration with `in_bit`=0 constant: settled outputs equal -512.
- Alternating 1,0 with R=8: settled outputs equal 0. Bitstream of pattern 1,1,1,0 repeated: settled outputs equal +256.
- `in_valid` toggling 50% with constant 1s: the sample period doubles to 16 cycles and values are identical to the continuous case. Integrators must hold on `in_valid`=0.
- `out_ready`=0 across two strobes: second sample replaces first, `overrun`=1 and remains set after `out_ready` returns. Also cover acceptance on the same cycle as a new sample: no overrun, `out_valid` stays high.
- Assert `reset` mid-frame (counter=5) for 1 cycle, then constant 1s. `out_data`=0 and `out_valid`=0 during reset. The first post-reset sample appears 9 cycles after release and the settled value is 512.
- Long run: 2^20 constant-1 bits with N=4, R=64. Integrators wrap, but settled output remains exactly +16777216 (B=26).
